// File: rtl/data_mem_responder.sv
// Single-request data RAM responder: accepts one load/store at a time and answers
// after a fixed latency, with byte-lane decode and sub-word load extension.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state, nextState;
  logic [CW-1:0]  cnt;
  logic           accept, commit;

  logic           capWe;
  logic [31:0]    capAddr;
  logic [2:0]     capSize;
  logic [31:0]    capWdata;

  logic [31:0]    mem [DEPTH_WORDS];
  logic [AW-1:0]  wordIdx;
  logic [31:0]    rdWord;

  logic [3:0]     byteEn;
  logic           misaligned, sizeBad, outOfRange, decErr;
  logic [31:0]    storeData;
  logic [31:0]    loadVal;
  logic [7:0]     byteSel;
  logic [15:0]    halfSel;

  assign req_ready  = (state == IDLE) && !rst;
  assign resp_valid = (state == RESP);

  assign wordIdx = capAddr[AW+1:2];
  assign rdWord  = mem[wordIdx];

  // LATENCY==1 still passes through one BUSY cycle (counter loaded with zero),
  // so resp_valid always appears exactly LATENCY cycles after the accept edge.
  always_comb begin
    nextState = state;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          accept    = 1'b1;
          nextState = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          commit    = 1'b1;
          nextState = RESP;
        end
      end
      RESP: begin
        if (resp_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    byteEn     = 4'b0000;
    misaligned = 1'b0;
    sizeBad    = 1'b0;
    storeData  = capWdata;
    case (capSize)
      3'b000, 3'b100: begin
        byteEn    = 4'b0001 << capAddr[1:0];
        storeData = {4{capWdata[7:0]}};
      end
      3'b001, 3'b101: begin
        byteEn     = capAddr[1] ? 4'b1100 : 4'b0011;
        misaligned = capAddr[0];
        storeData  = {2{capWdata[15:0]}};
      end
      3'b010: begin
        byteEn     = 4'b1111;
        misaligned = (capAddr[1:0] != 2'b00);
      end
      default: sizeBad = 1'b1;
    endcase
    outOfRange = ({2'b00, capAddr[31:2]} >= 32'(DEPTH_WORDS));
    decErr     = sizeBad || (capWe && capSize[2]) || misaligned || outOfRange;
  end

  always_comb begin
    byteSel = 8'(rdWord >> {capAddr[1:0], 3'b000});
    halfSel = capAddr[1] ? rdWord[31:16] : rdWord[15:0];
    case (capSize)
      3'b000:  loadVal = {{24{byteSel[7]}}, byteSel};
      3'b100:  loadVal = {24'h000000, byteSel};
      3'b001:  loadVal = {{16{halfSel[15]}}, halfSel};
      3'b101:  loadVal = {16'h0000, halfSel};
      3'b010:  loadVal = rdWord;
      default: loadVal = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= nextState;
      if (accept) begin
        cnt <= CW'(LATENCY - 1);
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (commit) begin
        resp_err   <= decErr;
        resp_rdata <= (decErr || capWe) ? '0 : loadVal;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      capWe    <= req_we;
      capAddr  <= req_addr;
      capSize  <= req_size;
      capWdata <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (commit && !rst && capWe && !decErr) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (byteEn[i]) mem[wordIdx][8*i +: 8] <= storeData[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed-vector bench for data_mem_responder: stores, sub-word loads, error
// cases, response backpressure and reset during a pending store.
module tb_data_mem_responder;

  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned LAT     = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid;
  logic        reqReady;
  logic        reqWe;
  logic [31:0] reqAddr;
  logic [2:0]  reqSize;
  logic [31:0] reqWdata;
  logic        respValid;
  logic        respReady;
  logic [31:0] respRdata;
  logic        respErr;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [2:0] SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010,
                         SZ_BU = 3'b100, SZ_HU = 3'b101;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (reqValid),
    .req_ready  (reqReady),
    .req_we     (reqWe),
    .req_addr   (reqAddr),
    .req_size   (reqSize),
    .req_wdata  (reqWdata),
    .resp_valid (respValid),
    .resp_ready (respReady),
    .resp_rdata (respRdata),
    .resp_err   (respErr)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents a request, waits for it to be accepted, then waits for resp_valid.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, input string tag);
    int n;
    reqWe = we; reqAddr = addr; reqSize = size; reqWdata = wdata; reqValid = 1'b1;
    n = 0;
    while (!reqReady && n < 20) begin @(posedge clk); #1; n++; end
    checkVal({tag, "/ready"}, {31'b0, reqReady}, 32'd1);
    @(posedge clk); #1;
    reqValid = 1'b0;
    n = 0;
    while (!respValid && n < 20) begin @(posedge clk); #1; n++; end
    checkVal({tag, "/latency"}, 32'(n), 32'(LAT));
  endtask

  task automatic doReq(input logic we, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, input logic [31:0] expRdata,
                       input logic expErr, input string tag);
    issue(we, addr, size, wdata, tag);
    checkVal({tag, "/rdata"}, respRdata, expRdata);
    checkVal({tag, "/err"}, {31'b0, respErr}, {31'b0, expErr});
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; reqValid = 1'b0; reqWe = 1'b0; reqAddr = '0; reqSize = '0;
    reqWdata = '0; respReady = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkVal("rst/resp_valid", {31'b0, respValid}, 32'd0);
    checkVal("rst/rdata", respRdata, 32'd0);
    checkVal("rst/err", {31'b0, respErr}, 32'd0);
    checkVal("rst/req_ready", {31'b0, reqReady}, 32'd0);
    rst = 1'b0;
    #1;
    checkVal("rst/ready_after", {31'b0, reqReady}, 32'd1);

    doReq(1'b1, 32'h10, SZ_W, 32'h12345678, 32'h0, 1'b0, "sw0");
    doReq(1'b0, 32'h10, SZ_W, 32'h0, 32'h12345678, 1'b0, "lw0");

    doReq(1'b1, 32'h13, SZ_B, 32'h00000080, 32'h0, 1'b0, "sb");
    doReq(1'b0, 32'h13, SZ_B, 32'h0, 32'hFFFFFF80, 1'b0, "lb13");
    doReq(1'b0, 32'h13, SZ_BU, 32'h0, 32'h00000080, 1'b0, "lbu13");
    doReq(1'b0, 32'h10, SZ_W, 32'h0, 32'h80345678, 1'b0, "lw_sb");

    doReq(1'b1, 32'h12, SZ_H, 32'h0000BEEF, 32'h0, 1'b0, "sh");
    doReq(1'b0, 32'h12, SZ_H, 32'h0, 32'hFFFFBEEF, 1'b0, "lh12");
    doReq(1'b0, 32'h12, SZ_HU, 32'h0, 32'h0000BEEF, 1'b0, "lhu12");
    doReq(1'b0, 32'h10, SZ_W, 32'h0, 32'hBEEF5678, 1'b0, "lw_sh");
    doReq(1'b0, 32'h12, SZ_B, 32'h0, 32'hFFFFFFEF, 1'b0, "lb12");
    doReq(1'b0, 32'h11, SZ_BU, 32'h0, 32'h00000056, 1'b0, "lbu11");
    doReq(1'b0, 32'h10, SZ_H, 32'h0, 32'h00005678, 1'b0, "lh10");

    doReq(1'b0, 32'h11, SZ_H, 32'h0, 32'h0, 1'b1, "lh_mis");
    doReq(1'b1, 32'h12, SZ_W, 32'hDEADBEEF, 32'h0, 1'b1, "sw_mis");
    doReq(1'b1, 32'h10, SZ_BU, 32'h000000AA, 32'h0, 1'b1, "sbu");
    doReq(1'b0, 32'h10, SZ_W, 32'h0, 32'hBEEF5678, 1'b0, "lw_noerrwr");
    doReq(1'b0, DEPTH * 4, SZ_W, 32'h0, 32'h0, 1'b1, "lw_oor");
    doReq(1'b1, DEPTH * 4 - 4, SZ_W, 32'hA5A5C3C3, 32'h0, 1'b0, "sw_top");
    doReq(1'b0, DEPTH * 4 - 4, SZ_W, 32'h0, 32'hA5A5C3C3, 1'b0, "lw_top");
    doReq(1'b0, 32'h10, 3'b011, 32'h0, 32'h0, 1'b1, "size011");
    doReq(1'b0, 32'h10, 3'b111, 32'h0, 32'h0, 1'b1, "size111");

    respReady = 1'b0;
    issue(1'b0, 32'h10, SZ_W, 32'h0, "bp");
    reqValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkVal("bp/resp_valid", {31'b0, respValid}, 32'd1);
      checkVal("bp/rdata", respRdata, 32'hBEEF5678);
      checkVal("bp/err", {31'b0, respErr}, 32'd0);
      checkVal("bp/req_ready", {31'b0, reqReady}, 32'd0);
      @(posedge clk); #1;
    end
    reqValid = 1'b0;
    respReady = 1'b1;
    @(posedge clk); #1;
    checkVal("bp/released", {31'b0, respValid}, 32'd0);
    checkVal("bp/ready_next", {31'b0, reqReady}, 32'd1);

    reqWe = 1'b1; reqAddr = 32'h10; reqSize = SZ_W; reqWdata = 32'h0; reqValid = 1'b1;
    @(posedge clk); #1;
    reqValid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    checkVal("rstbusy/resp_valid", {31'b0, respValid}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkVal("rstbusy/quiet", {31'b0, respValid}, 32'd0);
    end
    doReq(1'b0, 32'h10, SZ_W, 32'h0, 32'hBEEF5678, 1'b0, "lw_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
